// File: rtl/cache_data_array.sv
// Purpose : set-associative cache data store with byte-strobed store writes,
//           line refill beats, and a registered one-cycle read port.
// Ports   : rd_* read request/response, wr_* store write, rf_* line refill,
//           busy_o high while a refill owns the array.
module cache_data_array #(
    parameter  int WAY_NUM  = 2,
    parameter  int BANK_NUM = 4,
    parameter  int INDEX_W  = 8,
    parameter  int DATA_W   = 32,
    localparam int BW       = $clog2(BANK_NUM),
    localparam int SW       = DATA_W / 8
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               rd_req_i,
    output logic               rd_ready_o,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic [BW-1:0]      rd_bank_i,
    input  logic [WAY_NUM-1:0] rd_way_i,
    output logic               rd_valid_o,
    output logic [DATA_W-1:0]  rd_data_o,

    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [BW-1:0]      wr_bank_i,
    input  logic [WAY_NUM-1:0] wr_way_i,
    input  logic [SW-1:0]      wr_strb_i,
    input  logic [DATA_W-1:0]  wr_data_i,

    input  logic               rf_start_i,
    input  logic [INDEX_W-1:0] rf_index_i,
    input  logic [WAY_NUM-1:0] rf_way_i,
    input  logic               rf_valid_i,
    input  logic [DATA_W-1:0]  rf_data_i,
    output logic               rf_done_o,
    output logic               busy_o
);

    localparam int WW   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    // One-hot way vector to array index; only meaningful when the vector is one-hot.
    function automatic logic [WW-1:0] way_enc(input logic [WAY_NUM-1:0] v);
        logic [WW-1:0] r;
        r = '0;
        for (int i = 0; i < WAY_NUM; i++) begin
            if (v[i]) r = WW'(i);
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem [WAY_NUM][BANK_NUM][SETS];

    state_t             state, state_nxt;
    logic [BW-1:0]      cnt;
    logic [INDEX_W-1:0] rf_index_q;
    logic [WW-1:0]      rf_way_q;
    logic               rf_way_ok_q;

    logic               is_idle;
    logic               last_beat;
    logic               st_we;
    logic               rf_we;
    logic               rd_accept;
    logic [DATA_W-1:0]  rd_word;

    assign is_idle    = (state == IDLE);
    assign last_beat  = (cnt == BW'(BANK_NUM - 1));
    assign st_we      = wr_en_i && is_idle && $onehot(wr_way_i);
    // A refill latched with a malformed way still walks its beats but never writes.
    assign rf_we      = (state == REFILL) && rf_valid_i && rf_way_ok_q;
    assign rd_accept  = rd_req_i && is_idle;
    assign rd_ready_o = is_idle;
    assign busy_o     = (state == REFILL);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rf_start_i) state_nxt = REFILL;
            REFILL:  if (rf_valid_i && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read word with write-first forwarding of any same-cycle store to the same word.
    always_comb begin
        rd_word = '0;
        if ($onehot(rd_way_i)) begin
            rd_word = mem[way_enc(rd_way_i)][rd_bank_i][rd_index_i];
            if (st_we && (wr_way_i == rd_way_i) && (wr_index_i == rd_index_i) &&
                (wr_bank_i == rd_bank_i)) begin
                for (int k = 0; k < SW; k++) begin
                    if (wr_strb_i[k]) rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
                end
            end
        end
    end

    // Storage is never reset; store and refill writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (st_we) begin
            for (int k = 0; k < SW; k++) begin
                if (wr_strb_i[k])
                    mem[way_enc(wr_way_i)][wr_bank_i][wr_index_i][8*k +: 8] <= wr_data_i[8*k +: 8];
            end
        end
        if (rf_we) begin
            mem[rf_way_q][cnt][rf_index_q] <= rf_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rf_index_q  <= '0;
            rf_way_q    <= '0;
            rf_way_ok_q <= 1'b0;
            rf_done_o   <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
        end else begin
            state <= state_nxt;
            if (is_idle && rf_start_i) begin
                rf_index_q  <= rf_index_i;
                rf_way_q    <= way_enc(rf_way_i);
                rf_way_ok_q <= $onehot(rf_way_i);
                cnt         <= '0;
            end else if ((state == REFILL) && rf_valid_i) begin
                cnt <= cnt + 1'b1;
            end
            rf_done_o  <= (state == REFILL) && rf_valid_i && last_beat;
            rd_valid_o <= rd_accept;
            if (rd_accept) rd_data_o <= rd_word;
        end
    end

endmodule
